text_buffer_writer: RTL and testbench

// - Writer/owner of the 64-char text buffer that the text renderer reads, 4 rows x 16 cols.
// - Accepts a byte stream (UART/SD-card data) on a valid/ready handshake.
// - Stores printable chars at a cursor and interprets CR/LF/BS/FF.
// - Wraps or scrolls at the bottom row.
// - Serves the renderer's read port: charAddress -> charOutput, combinational, same-cycle.

---
 rtl/text_buffer_writer_pkg.sv | 25 ++
 rtl/text_buffer_writer_ram.sv | 26 ++
 rtl/text_buffer_writer.sv | 169 ++++++++++++++++
 tb/tb_text_buffer_writer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_buffer_writer_pkg.sv
// Shared definitions for the text buffer writer: character codes,
// buffer geometry and FSM state encodings.
package text_buffer_writer_pkg;

  localparam int unsigned ROW_BITS = 2;
  localparam int unsigned COL_BITS = 4;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] PRINT_MAX  = 8'h7E;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLR_ALL = 2'd1;
  localparam logic [1:0] ST_SCROLL  = 2'd2;
  localparam logic [1:0] ST_CLR_ROW = 2'd3;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_buffer_writer_ram.sv
// 64x8 character store.
//   clk                        write clock
//   we_i/waddr_i/wdata_i       synchronous write port
//   raddr_a_i -> rdata_a_o     asynchronous read (renderer)
//   raddr_b_i -> rdata_b_o     asynchronous read (scroll source)
module text_buffer_writer_ram (
  input  logic       clk,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [5:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] mem_q [64];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/text_buffer_writer.sv
// Owner of the 4x16 text buffer read by the renderer. Consumes a byte stream
// on a valid/ready handshake, stores printable characters at the cursor and
// interprets CR/LF/BS/FF; wraps or scrolls at the bottom row.
//   clk, reset        single clock, synchronous active-high reset
//   in_data/in_valid  input byte stream
//   in_ready          high only in IDLE
//   busy              clear/scroll sequence running (== !in_ready)
//   cursor_addr       {row,col} of the next write
//   charAddress       renderer read address {row,col}
//   charOutput        buffer[charAddress], same cycle
// Buffer contents have no reset; the CLR_ALL sequence entered on reset
// establishes them.
module text_buffer_writer
  import text_buffer_writer_pkg::*;
#(
  parameter int SCROLL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [5:0] cursor_addr,
  input  logic [5:0] charAddress,
  output logic [7:0] charOutput
);

  logic [1:0]          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [5:0]          cursor_q, cursor_d;
  logic [ROW_BITS-1:0] row_clr_q, row_clr_d;

  logic                we;
  logic [5:0]          waddr;
  logic [7:0]          wdata;
  logic [7:0]          scroll_src;
  logic                newline;

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;

  assign row = cursor_q[5:4];
  assign col = cursor_q[3:0];

  text_buffer_writer_ram u_ram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (charAddress),
    .rdata_a_o (charOutput),
    .raddr_b_i (cnt_q + 6'd16),
    .rdata_b_o (scroll_src)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cursor_d  = cursor_q;
    row_clr_d = row_clr_q;
    we        = 1'b0;
    waddr     = cursor_q;
    wdata     = CHAR_SPACE;
    newline   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_print(in_data)) begin
            we            = 1'b1;
            wdata         = in_data;
            cursor_d[3:0] = col + 4'd1;
            newline       = (col == 4'hF);
          end else begin
            case (in_data)
              CHAR_LF: begin
                cursor_d[3:0] = '0;
                newline       = 1'b1;
              end
              CHAR_CR: cursor_d[3:0] = '0;
              CHAR_BS: begin
                if (col != '0) begin
                  cursor_d[3:0] = col - 4'd1;
                  we            = 1'b1;
                  waddr         = {row, col - 4'd1};
                end
              end
              CHAR_FF: begin
                cursor_d = '0;
                cnt_d    = '0;
                state_d  = ST_CLR_ALL;
              end
              default: ;
            endcase
          end

          // The cursor's row already advanced on this edge, so the sequence
          // that follows only has to clean up the buffer.
          if (newline) begin
            cnt_d = '0;
            if (row != 2'd3) begin
              cursor_d[5:4] = row + 2'd1;
              row_clr_d     = row + 2'd1;
              state_d       = ST_CLR_ROW;
            end else if (SCROLL_EN != 0) begin
              state_d = ST_SCROLL;
            end else begin
              cursor_d[5:4] = '0;
              row_clr_d     = '0;
              state_d       = ST_CLR_ROW;
            end
          end
        end
      end

      ST_CLR_ALL: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          cursor_d = '0;
          state_d  = ST_IDLE;
        end
      end

      ST_SCROLL: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = scroll_src;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd47) begin
          cnt_d     = '0;
          row_clr_d = 2'd3;
          state_d   = ST_CLR_ROW;
        end
      end

      default: begin // ST_CLR_ROW
        we    = 1'b1;
        waddr = {row_clr_q, cnt_q[3:0]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd15) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLR_ALL;
      cnt_q     <= '0;
      cursor_q  <= '0;
      row_clr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cursor_q  <= cursor_d;
      row_clr_q <= row_clr_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign cursor_addr = cursor_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

  localparam int SCROLL_EN = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy;
  logic [5:0] cursor_addr;
  logic [5:0] charAddress = 6'd0;
  logic [7:0] charOutput;

  text_buffer_writer #(.SCROLL_EN(SCROLL_EN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .busy        (busy),
    .cursor_addr (cursor_addr),
    .charAddress (charAddress),
    .charOutput  (charOutput)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (screen-level view) ----------------
  logic [7:0] m_buf [64];
  int         m_row = 0, m_col = 0, m_busy = 0;
  bit         known = 0;

  function automatic void m_clear_row(input int r);
    for (int c = 0; c < 16; c++) m_buf[r*16+c] = 8'h20;
  endfunction

  function automatic void m_newline();
    m_col = 0;
    if (m_row < 3) begin
      m_row++;
      m_clear_row(m_row);
      m_busy = 16;
    end else if (SCROLL_EN != 0) begin
      for (int i = 0; i < 48; i++) m_buf[i] = m_buf[i+16];
      m_clear_row(3);
      m_busy = 64;
    end else begin
      m_row = 0;
      m_clear_row(0);
      m_busy = 16;
    end
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_buf[m_row*16+m_col] = b;
      if (m_col == 15) m_newline();
      else m_col++;
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_buf[m_row*16+m_col] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int i = 0; i < 64; i++) m_buf[i] = 8'h20;
      m_busy = 64;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      known = 1;
      for (int i = 0; i < 64; i++) m_buf[i] = 8'h20;
      m_row = 0; m_col = 0; m_busy = 64;
    end else if (known) begin
      if (m_busy > 0) m_busy--;
      else if (in_valid) m_accept(in_data);
    end
  end

  // Per-cycle monitor: handshake, cursor and a rotating read address.
  logic [5:0] rot = 6'd0;
  always @(negedge clk) begin
    if (known) begin
      charAddress = rot;
      #1;
      chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
      chk("busy", 32'(busy), 32'(m_busy != 0));
      chk("cursor_addr", 32'(cursor_addr), 32'(m_row*16 + m_col));
      if (m_busy == 0) chk("charOutput", 32'(charOutput), 32'(m_buf[rot]));
      rot = rot + 6'd1;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic read_chk(input string name, input logic [5:0] a, input logic [7:0] exp);
    @(posedge clk);
    #3;
    charAddress = a;
    #1;
    chk(name, 32'(charOutput), 32'(exp));
  endtask

  // Called at a negedge; counts samples with in_ready low.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    #2;
    while (!in_ready) begin
      cycles++;
      if (cycles > 300) begin
        chk("wait_idle_timeout", 32'(cycles), 32'd0);
        return;
      end
      @(negedge clk);
      #2;
    end
  endtask

  // Presents one byte, returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      guard++;
      if (guard > 300) begin
        chk("send_timeout", 32'(guard), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [7:0] b, output int cycles);
    send_byte(b);
    wait_idle(cycles);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    int          exp_busy;
    logic [5:0]  exp_cursor;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    logic [7:0] burst [5];
    int r;

    // Starts from cursor 2 (after "HI"); expectations derived by hand.
    tbl[0]  = '{8'h08, 0,  6'd1};   // BS
    tbl[1]  = '{8'h08, 0,  6'd0};   // BS
    tbl[2]  = '{8'h08, 0,  6'd0};   // BS at col 0: no-op
    tbl[3]  = '{8'h58, 0,  6'd1};   // 'X'
    tbl[4]  = '{8'h08, 0,  6'd0};   // BS erases 'X'
    tbl[5]  = '{8'h51, 0,  6'd1};   // 'Q'
    tbl[6]  = '{8'h0D, 0,  6'd0};   // CR
    tbl[7]  = '{8'h0A, 16, 6'd16};  // LF -> clear row 1
    tbl[8]  = '{8'h01, 0,  6'd16};  // dropped
    tbl[9]  = '{8'h7F, 0,  6'd16};  // dropped
    tbl[10] = '{8'h0A, 16, 6'd32};
    tbl[11] = '{8'h0A, 16, 6'd48};
    tbl[12] = '{8'h5A, 0,  6'd49};  // 'Z' at row 3
    tbl[13] = '{8'h0A, 64, 6'd48};  // scroll
    tbl[14] = '{8'h31, 0,  6'd49};  // '1'
    tbl[15] = '{8'h0C, 64, 6'd0};   // FF

    // T1: reset
    do_reset();
    wait_idle(cyc);
    chk("T1_reset_busy_cycles", 32'(cyc), 32'd64);
    chk("T1_cursor", 32'(cursor_addr), 32'd0);
    for (int a = 0; a < 64; a++) read_chk("T1_space", 6'(a), 8'h20);

    // T2: "HI"
    send_wait(8'h48, cyc);
    send_wait(8'h49, cyc);
    read_chk("T2_addr0", 6'd0, 8'h48);
    read_chk("T2_addr1", 6'd1, 8'h49);
    chk("T2_cursor", 32'(cursor_addr), 32'd2);

    // Table-driven control characters / newline / scroll
    for (int i = 0; i < 16; i++) begin
      send_wait(tbl[i].b, cyc);
      chk($sformatf("TBL%0d_busy", i), 32'(cyc), 32'(tbl[i].exp_busy));
      chk($sformatf("TBL%0d_cursor", i), 32'(cursor_addr), 32'(tbl[i].exp_cursor));
      if (i == 4) read_chk("T5_bs_erased", 6'd0, 8'h20);
      if (i == 14) begin
        read_chk("TBL_scroll_Z", 6'd32, 8'h5A);
        read_chk("TBL_scroll_row0", 6'd0, 8'h20);
        read_chk("TBL_one", 6'd48, 8'h31);
      end
    end
    read_chk("T5_ff_clear", 6'd32, 8'h20);

    // T3: 17 x 'A'
    for (int i = 0; i < 17; i++) begin
      send_wait(8'h41, cyc);
      chk("T3_busy", 32'(cyc), (i == 15) ? 32'd16 : 32'd0);
    end
    chk("T3_cursor", 32'(cursor_addr), 32'd17);
    read_chk("T3_addr0", 6'd0, 8'h41);
    read_chk("T3_addr16", 6'd16, 8'h41);
    read_chk("T3_addr17", 6'd17, 8'h20);

    // T4: fill rows 0..2, partial row 3, LF scrolls
    send_wait(8'h0C, cyc);
    for (int i = 0; i < 48; i++) send_wait(8'h61 + 8'(i / 16), cyc);
    send_wait(8'h64, cyc);
    send_wait(8'h65, cyc);
    chk("T4_cursor_pre", 32'(cursor_addr), 32'd50);
    send_wait(8'h0A, cyc);
    chk("T4_scroll_busy", 32'(cyc), 32'd64);
    chk("T4_cursor", 32'(cursor_addr), 32'd48);
    read_chk("T4_r0c0", 6'd0, 8'h62);
    read_chk("T4_r0c15", 6'd15, 8'h62);
    read_chk("T4_r1c0", 6'd16, 8'h63);
    read_chk("T4_r2c0", 6'd32, 8'h64);
    read_chk("T4_r2c1", 6'd33, 8'h65);
    read_chk("T4_r2c2", 6'd34, 8'h20);
    read_chk("T4_r3c0", 6'd48, 8'h20);
    read_chk("T4_r3c15", 6'd63, 8'h20);

    // T6: reset in the middle of a scroll
    send_byte(8'h0A);
    repeat (20) @(posedge clk);
    do_reset();
    wait_idle(cyc);
    chk("T6_busy", 32'(cyc), 32'd64);
    chk("T6_cursor", 32'(cursor_addr), 32'd0);
    read_chk("T6_addr0", 6'd0, 8'h20);
    read_chk("T6_addr20", 6'd20, 8'h20);

    // in_valid held high across a busy period
    burst[0] = 8'h41; burst[1] = 8'h42; burst[2] = 8'h0A;
    burst[3] = 8'h43; burst[4] = 8'h44;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int g = 0;
      in_data = burst[i];
      #1;
      while (!in_ready && g < 300) begin
        @(negedge clk);
        #1;
        g++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle(cyc);
    chk("HOLD_cursor", 32'(cursor_addr), 32'd18);
    read_chk("HOLD_a0", 6'd0, 8'h41);
    read_chk("HOLD_a1", 6'd1, 8'h42);
    read_chk("HOLD_a2", 6'd2, 8'h20);
    read_chk("HOLD_a16", 6'd16, 8'h43);
    read_chk("HOLD_a17", 6'd17, 8'h44);

    // Randomised stream checked by the per-cycle monitor against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 99));
      if (r < 70)      in_data = 8'($urandom_range(32'h20, 32'h7E));
      else if (r < 78) in_data = 8'h0A;
      else if (r < 84) in_data = 8'h0D;
      else if (r < 93) in_data = 8'h08;
      else if (r < 94) in_data = 8'h0C;
      else             in_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(cyc);
    repeat (70) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
